// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared defaults and bit-order type for the deserializer FIFO
// Purpose: default word width / FIFO depth and the bit-order enumeration.
// Ports: none (package).
package deser_pkg;

  localparam int DESER_WIDTH_DEF = 8;
  localparam int DESER_DEPTH_DEF = 4;

  typedef enum logic {
    BIT_LSB_FIRST = 1'b0,
    BIT_MSB_FIRST = 1'b1
  } bit_order_e;

endpackage

// File: rtl/deserializer_fifo_if.sv
// rtl/deserializer_fifo_if.sv - serial input / word output bundle of the deserializer FIFO
// Purpose: groups the serial bit strobe, control strobes and the buffered word outputs.
// Ports (master = producer/consumer side, slave = deserializer side):
//   data_in, write_in, flush_in, ack_in          master -> slave
//   data_out, data_ready, status_out,
//   fill_level, overflow_out                     slave -> master
interface deserializer_fifo_if
  import deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEF,
  parameter int DEPTH = DESER_DEPTH_DEF
) ();

  localparam int CW = $clog2(DEPTH + 1);

  logic             data_in;
  logic             write_in;
  logic             flush_in;
  logic             ack_in;
  logic [WIDTH-1:0] data_out;
  logic             data_ready;
  logic             status_out;
  logic [CW-1:0]    fill_level;
  logic             overflow_out;

  modport master (
    output data_in, write_in, flush_in, ack_in,
    input  data_out, data_ready, status_out, fill_level, overflow_out
  );

  modport slave (
    input  data_in, write_in, flush_in, ack_in,
    output data_out, data_ready, status_out, fill_level, overflow_out
  );

endinterface

// File: rtl/deser_word_fifo.sv
// rtl/deser_word_fifo.sv - synchronous show-ahead word FIFO
// Purpose: DEPTH-entry word buffer; head word is visible without a read strobe, zero when empty.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   write a word (ignored when full)
//   pop               drop the head word (ignored when empty)
//   flush             synchronous clear of pointers and count
//   head_data         current head word, 0 when empty
//   full, empty       occupancy flags from the registered count
//   count             number of stored words (0..DEPTH)
module deser_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push & ~full;
    do_pop   = pop & ~empty;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leave the count unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/deserializer_fifo.sv
// rtl/deserializer_fifo.sv - serial-to-parallel receiver with word FIFO
// Purpose: shifts WIDTH qualified serial bits into a word, queues completed words, reports overflow.
// Ports:
//   clk_100mhz   sole clock, rising edge
//   reset        synchronous active-high reset
//   bus          deserializer_fifo_if.slave (serial in, strobes, buffered word out, status)
module deserializer_fifo
  import deser_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH_DEF,
  parameter int DEPTH     = DESER_DEPTH_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk_100mhz,
  input  logic                reset,
  deserializer_fifo_if.slave  bus
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam bit_order_e ORDER = bit_order_e'(MSB_FIRST != 0);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] sr_shift;
  logic             accept, push;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [WIDTH-1:0] fifo_head;

  always_comb begin
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    overflow_d = overflow_q;
    sr_shift   = (ORDER == BIT_MSB_FIRST) ? {sr_q[WIDTH-2:0], bus.data_in}
                                          : {bus.data_in, sr_q[WIDTH-1:1]};
    // Fullness comes from the registered count, so a same-cycle pop never admits a bit.
    accept     = bus.write_in & ~fifo_full;
    push       = accept & (bit_cnt_q == LAST_BIT);

    if (accept) begin
      sr_d      = sr_shift;
      bit_cnt_d = push ? '0 : bit_cnt_q + 1'b1;
    end
    if (bus.write_in & fifo_full) begin
      overflow_d = 1'b1;
    end

    if (bus.flush_in) begin
      sr_d       = '0;
      bit_cnt_d  = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // The word pushed on the final bit already includes that bit (sr_shift, not sr_q).
  deser_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_100mhz),
    .reset     (reset),
    .push      (push),
    .push_data (sr_shift),
    .pop       (bus.ack_in),
    .flush     (bus.flush_in),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.data_out     = fifo_head;
  assign bus.data_ready   = ~fifo_empty;
  assign bus.status_out   = ~fifo_full;
  assign bus.fill_level   = fifo_count;
  assign bus.overflow_out = overflow_q;

endmodule

// File: tb/tb_deserializer_fifo.sv
// tb/tb_deserializer_fifo.sv - self-checking bench for deserializer_fifo
module tb_deserializer_fifo;
  import deser_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  deserializer_fifo_if #(.WIDTH(8), .DEPTH(4)) bus_m ();
  deserializer_fifo_if #(.WIDTH(8), .DEPTH(4)) bus_l ();

  deserializer_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) dut_m (
    .clk_100mhz (clk),
    .reset      (reset),
    .bus        (bus_m)
  );

  deserializer_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) dut_l (
    .clk_100mhz (clk),
    .reset      (reset),
    .bus        (bus_l)
  );

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_l;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic d, input logic w, input logic a, input logic f);
    bus_m.data_in = d;  bus_m.write_in = w;  bus_m.ack_in = a;  bus_m.flush_in = f;
    bus_l.data_in = d;  bus_l.write_in = w;  bus_l.ack_in = a;  bus_l.flush_in = f;
  endtask

  task automatic send_bit(input logic b);
    drive(b, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends w first bit = w[7]; optional ack on the final bit pops the current head.
  task automatic send_word(input logic [7:0] w, input bit ack_last, input string name);
    for (int i = 7; i >= 0; i--) begin
      drive(w[i], 1'b1, (ack_last && i == 0), 1'b0);
      if (i == 0) begin
        if (ack_last) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_head: scoreboard empty, expected a word", name);
          end else begin
            check({name, "_head"}, bus_m.data_out, exp_q.pop_front());
          end
        end
        exp_q.push_back(w);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ack_pop(input string name);
    check({name, "_ready"}, bus_m.data_ready, 1);
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", name, bus_m.data_out);
    end else begin
      check(name, bus_m.data_out, exp_q.pop_front());
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_idle(input string name);
    check({name, "_ready"},    bus_m.data_ready,   0);
    check({name, "_status"},   bus_m.status_out,   1);
    check({name, "_data"},     bus_m.data_out,     0);
    check({name, "_fill"},     bus_m.fill_level,   0);
    check({name, "_overflow"}, bus_m.overflow_out, 0);
  endtask

  initial begin
    vecs[0] = '{8'h55, 8'hAA};
    vecs[1] = '{8'h01, 8'h80};
    vecs[2] = '{8'hF0, 8'h0F};
    vecs[3] = '{8'h3A, 8'h5C};

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("t1_reset");

    // Both bit orders from the same serial stream.
    for (int i = 0; i < 4; i++) begin
      send_word(vecs[i].word, 1'b0, "t2");
      check($sformatf("t2_fill[%0d]", i),   bus_m.fill_level, 1);
      check($sformatf("t2_lsb[%0d]", i),    bus_l.data_out,   vecs[i].exp_l);
      ack_pop($sformatf("t2_msb[%0d]", i));
      check($sformatf("t2_empty[%0d]", i),  bus_m.data_ready, 0);
    end

    // Fill, overflow, drain in order.
    send_word(8'h11, 1'b0, "t3");
    send_word(8'h22, 1'b0, "t3");
    send_word(8'h33, 1'b0, "t3");
    send_word(8'h44, 1'b0, "t3");
    check("t3_status_full", bus_m.status_out, 0);
    check("t3_fill_full",   bus_m.fill_level, 4);
    check("t3_no_ovf_yet",  bus_m.overflow_out, 0);
    send_bit(1'b1);
    check("t3_overflow",    bus_m.overflow_out, 1);
    check("t3_fill_after",  bus_m.fill_level, 4);
    for (int i = 0; i < 4; i++) begin
      ack_pop($sformatf("t3_drain[%0d]", i));
      check($sformatf("t3_fill_drain[%0d]", i), bus_m.fill_level, 3 - i);
    end
    check("t3_ready_end", bus_m.data_ready, 0);
    check("t3_data_end",  bus_m.data_out,   0);
    check("t3_ovf_sticky", bus_m.overflow_out, 1);

    // Push and pop on the same edge.
    send_word(8'h11, 1'b0, "t4");
    check("t4_fill_pre", bus_m.fill_level, 1);
    send_word(8'h22, 1'b1, "t4");
    check("t4_fill_post", bus_m.fill_level, 1);
    check("t4_head_post", bus_m.data_out, 8'h22);
    ack_pop("t4_pop");

    // Reset mid-word.
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("t5_reset");
    send_word(8'hA5, 1'b0, "t5");
    check("t5_lsb", bus_l.data_out, 8'hA5);
    ack_pop("t5_word");

    // Flush with stored words, partial bits and overflow pending.
    send_word(8'h12, 1'b0, "t6");
    send_word(8'h34, 1'b0, "t6");
    send_word(8'h56, 1'b0, "t6");
    send_word(8'h78, 1'b0, "t6");
    send_bit(1'b0);
    ack_pop("t6_pre0");
    ack_pop("t6_pre1");
    check("t6_fill_pre", bus_m.fill_level, 2);
    check("t6_ovf_pre",  bus_m.overflow_out, 1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    check_idle("t6_flush");
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_ack_empty_fill",  bus_m.fill_level, 0);
    check("t6_ack_empty_ready", bus_m.data_ready, 0);
    send_word(8'h3C, 1'b0, "t6");
    check("t6_fill_new", bus_m.fill_level, 1);
    ack_pop("t6_word");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
